// File: rtl/i2c_master_reader_if.sv
// Bus bundle for i2c_master_reader: request/capture inputs, open-drain line
// enables and the transaction status/result outputs.
interface i2c_master_reader_if #(
  parameter int ADDRESSLENGTH = 7,
  parameter int NBYTES        = 2
);
  logic                     START;
  logic [ADDRESSLENGTH-1:0] ADDRESS;
  logic [7:0]               POINTER;
  logic                     SDA_IN;
  logic                     SDA_OE;
  logic                     SCL_OE;
  logic                     BUSY;
  logic                     DONE;
  logic                     ACK_ERR;
  logic [8*NBYTES-1:0]      DATA;

  modport master (
    input  START, ADDRESS, POINTER, SDA_IN,
    output SDA_OE, SCL_OE, BUSY, DONE, ACK_ERR, DATA
  );

  modport slave (
    output START, ADDRESS, POINTER, SDA_IN,
    input  SDA_OE, SCL_OE, BUSY, DONE, ACK_ERR, DATA
  );
endinterface

// File: rtl/i2c_master_reader.sv
// I2C register reader: START, address+W, pointer, repeated START, address+R,
// NBYTES data bytes (master ACKs all but the last), STOP.
module i2c_master_reader #(
  parameter int ADDRESSLENGTH = 7,
  parameter int NBYTES        = 2,
  parameter int CLKDIV        = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  i2c_master_reader_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, START_C, ADDR_W, ACK_A, PTR, ACK_P, RSTART,
    ADDR_R, ACK_R, RD_BYTE, M_ACK, STOP_C
  } state_t;

  localparam int TW = (ADDRESSLENGTH + 1 > 8) ? ADDRESSLENGTH + 1 : 8;
  localparam int DW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam int RW = 8 * NBYTES;

  state_t                   state_reg, state_next;
  logic [1:0]               q_reg, q_next;
  logic [DW-1:0]            div_reg, div_next;
  logic [7:0]               bit_reg, bit_next;
  logic [2:0]               byte_reg, byte_next;
  logic [TW-1:0]            tx_reg, tx_next;
  logic [RW-1:0]            rx_reg, rx_next;
  logic [RW-1:0]            data_reg, data_next;
  logic [ADDRESSLENGTH-1:0] addr_reg, addr_next;
  logic [7:0]               ptr_reg, ptr_next;
  logic                     nack_reg, nack_next;
  logic                     done_reg, done_next;
  logic                     ack_err_reg, ack_err_next;

  logic tick, last_addr_bit, last_bit, last_byte, bit_scl_low;
  logic sda_oe, scl_oe;
  logic [TW-1:0] addr_w_word, addr_r_word, ptr_word;

  assign tick          = (state_reg != IDLE) && (div_reg == DW'(CLKDIV - 1));
  assign last_addr_bit = (bit_reg == 8'(ADDRESSLENGTH));
  assign last_bit      = (bit_reg == 8'd7);
  assign last_byte     = (byte_reg == 3'(NBYTES - 1));
  assign bit_scl_low   = (q_reg == 2'd0) || (q_reg == 2'd3);

  // Transmit words are left-aligned so the MSB of tx_reg is always the bit on the wire.
  assign addr_w_word = TW'({addr_reg, 1'b0}) << (TW - ADDRESSLENGTH - 1);
  assign addr_r_word = TW'({addr_reg, 1'b1}) << (TW - ADDRESSLENGTH - 1);
  assign ptr_word    = TW'(ptr_reg) << (TW - 8);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      q_reg       <= '0;
      div_reg     <= '0;
      bit_reg     <= '0;
      byte_reg    <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      data_reg    <= '0;
      addr_reg    <= '0;
      ptr_reg     <= '0;
      nack_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ack_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      q_reg       <= q_next;
      div_reg     <= div_next;
      bit_reg     <= bit_next;
      byte_reg    <= byte_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      data_reg    <= data_next;
      addr_reg    <= addr_next;
      ptr_reg     <= ptr_next;
      nack_reg    <= nack_next;
      done_reg    <= done_next;
      ack_err_reg <= ack_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    q_next       = q_reg;
    div_next     = div_reg;
    bit_next     = bit_reg;
    byte_next    = byte_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    data_next    = data_reg;
    addr_next    = addr_reg;
    ptr_next     = ptr_reg;
    nack_next    = nack_reg;
    ack_err_next = ack_err_reg;
    done_next    = 1'b0;

    if (state_reg == IDLE) begin
      div_next = '0;
      q_next   = '0;
      // done_reg blocks a START that lands in the DONE cycle.
      if (bus.START && !done_reg) begin
        state_next   = START_C;
        addr_next    = bus.ADDRESS;
        ptr_next     = bus.POINTER;
        bit_next     = '0;
        byte_next    = '0;
        rx_next      = '0;
        nack_next    = 1'b0;
        ack_err_next = 1'b0;
      end
    end else begin
      div_next = tick ? '0 : div_reg + 1'b1;
      if (tick) begin
        q_next = q_reg + 2'd1;
        if (q_reg == 2'd2) begin
          if ((state_reg == ACK_A || state_reg == ACK_P || state_reg == ACK_R) && bus.SDA_IN)
            nack_next = 1'b1;
          if (state_reg == RD_BYTE)
            rx_next = {rx_reg[RW-2:0], bus.SDA_IN};
        end
        if (q_reg == 2'd3) begin
          case (state_reg)
            START_C: begin
              state_next = ADDR_W;
              tx_next    = addr_w_word;
              bit_next   = '0;
            end
            ADDR_W, ADDR_R: begin
              if (last_addr_bit) begin
                state_next = (state_reg == ADDR_W) ? ACK_A : ACK_R;
                bit_next   = '0;
              end else begin
                bit_next = bit_reg + 8'd1;
                tx_next  = tx_reg << 1;
              end
            end
            ACK_A: begin
              state_next = nack_reg ? STOP_C : PTR;
              tx_next    = ptr_word;
              bit_next   = '0;
            end
            PTR: begin
              if (last_bit) begin
                state_next = ACK_P;
                bit_next   = '0;
              end else begin
                bit_next = bit_reg + 8'd1;
                tx_next  = tx_reg << 1;
              end
            end
            ACK_P:  state_next = nack_reg ? STOP_C : RSTART;
            RSTART: begin
              state_next = ADDR_R;
              tx_next    = addr_r_word;
              bit_next   = '0;
            end
            ACK_R: begin
              state_next = nack_reg ? STOP_C : RD_BYTE;
              bit_next   = '0;
            end
            RD_BYTE: begin
              if (last_bit) begin
                state_next = M_ACK;
                bit_next   = '0;
              end else begin
                bit_next = bit_reg + 8'd1;
              end
            end
            M_ACK: begin
              if (last_byte) begin
                state_next = STOP_C;
              end else begin
                state_next = RD_BYTE;
                byte_next  = byte_reg + 3'd1;
              end
            end
            default: ;
          endcase
        end
        // STOP is three quarters long; its last tick closes the transaction.
        if (state_reg == STOP_C && q_reg == 2'd2) begin
          state_next   = IDLE;
          q_next       = '0;
          done_next    = 1'b1;
          ack_err_next = nack_reg;
          if (!nack_reg)
            data_next = rx_reg;
        end
      end
    end
  end

  always_comb begin
    sda_oe = 1'b0;
    scl_oe = 1'b0;
    case (state_reg)
      START_C, RSTART: begin
        sda_oe = q_reg[1];
        scl_oe = (q_reg == 2'd3);
      end
      ADDR_W, PTR, ADDR_R: begin
        sda_oe = ~tx_reg[TW-1];
        scl_oe = bit_scl_low;
      end
      ACK_A, ACK_P, ACK_R, RD_BYTE: scl_oe = bit_scl_low;
      M_ACK: begin
        sda_oe = ~last_byte;
        scl_oe = bit_scl_low;
      end
      STOP_C: begin
        sda_oe = ~q_reg[1];
        scl_oe = (q_reg == 2'd0);
      end
      default: ;
    endcase
  end

  assign bus.SDA_OE  = sda_oe;
  assign bus.SCL_OE  = scl_oe;
  assign bus.BUSY    = (state_reg != IDLE);
  assign bus.DONE    = done_reg;
  assign bus.ACK_ERR = ack_err_reg;
  assign bus.DATA    = data_reg;

endmodule

// File: tb/tb_i2c_master_reader.sv
// Bench for i2c_master_reader: behavioural bus slave plus scoreboard queues for
// bus bytes, master ACK bits, DATA and ACK_ERR.
module tb_i2c_master_reader;

  localparam int AL     = 7;
  localparam int NB     = 2;
  localparam int CLKDIV = 4;
  localparam int TMO    = 4000;
  localparam int Q_FULL = 4 + 9*4 + 9*4 + 4 + 9*4 + NB*9*4 + 3;
  localparam int Q_NACK = 4 + 9*4 + 3;

  logic CLK, RST_N;
  i2c_master_reader_if #(.ADDRESSLENGTH(AL), .NBYTES(NB)) bus();

  i2c_master_reader #(.ADDRESSLENGTH(AL), .NBYTES(NB), .CLKDIV(CLKDIV)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, busy_cnt = 0, done_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic slave_low = 1'b0;
  bit   slave_nack_addr = 1'b0;
  bit   s_reading = 1'b0;
  logic [7:0]  exp_bytes[$], rd_bytes[$];
  logic        exp_mack[$], exp_err[$];
  logic [15:0] exp_data[$];
  logic [15:0] model_data = 16'h0000;

  assign bus.SDA_IN = ~(bus.SDA_OE | slave_low);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (bus.BUSY) busy_cnt++;
    if (bus.DONE) done_cnt++;
  end

  // Bus slave: watches SCL/SDA edges, checks master bytes, ACKs, returns read data.
  initial begin
    logic scl_p, sda_p, scl_n, sda_n, s_first;
    logic [7:0] s_byte, s_tx, eb;
    int s_cnt;
    scl_p = 1'b1; sda_p = 1'b1; s_first = 1'b0; s_cnt = 0; s_byte = '0; s_tx = '0;
    forever begin
      @(negedge CLK);
      scl_n = ~bus.SCL_OE;
      sda_n = bus.SDA_IN;
      if (!RST_N) begin
        s_cnt = 0; s_reading = 1'b0; s_first = 1'b0; slave_low = 1'b0;
        scl_n = 1'b1; sda_n = 1'b1;
      end else if (scl_n && scl_p && sda_p && !sda_n) begin
        start_cnt++; s_cnt = 0; s_reading = 1'b0; s_first = 1'b1; slave_low = 1'b0;
      end else if (scl_n && scl_p && !sda_p && sda_n) begin
        stop_cnt++; s_cnt = 0; s_reading = 1'b0; s_first = 1'b0; slave_low = 1'b0;
      end else if (scl_n && !scl_p) begin
        if (s_cnt < 8) begin
          if (s_reading) s_tx = s_tx << 1;
          else           s_byte = {s_byte[6:0], sda_n};
          s_cnt++;
          if (s_cnt == 8 && !s_reading) begin
            vectors++;
            if (exp_bytes.size() == 0) begin
              $display("FAIL bus_byte got %h want none", s_byte); miscompares++;
            end else begin
              eb = exp_bytes.pop_front();
              if (s_byte !== eb) begin
                $display("FAIL bus_byte got %h want %h", s_byte, eb); miscompares++;
              end
            end
          end
        end else begin
          if (s_reading) begin
            vectors++;
            if (exp_mack.size() == 0) begin
              $display("FAIL master_ack got %b want none", sda_n); miscompares++;
            end else if (sda_n !== exp_mack.pop_front()) begin
              $display("FAIL master_ack got %b want %b", sda_n, ~sda_n); miscompares++;
            end
            if (sda_n) s_reading = 1'b0;
            else if (rd_bytes.size() != 0) s_tx = rd_bytes.pop_front();
          end else if (s_first) begin
            s_first = 1'b0;
            if (s_byte[0] && !slave_nack_addr) begin
              s_reading = 1'b1;
              s_tx = (rd_bytes.size() != 0) ? rd_bytes.pop_front() : 8'hFF;
            end
          end
          s_cnt = 0;
        end
      end else if (!scl_n && scl_p) begin
        if (s_cnt == 8 && !s_reading) slave_low = !(s_first && slave_nack_addr);
        else if (s_reading && s_cnt < 8) slave_low = ~s_tx[7];
        else slave_low = 1'b0;
      end
      scl_p = scl_n;
      sda_p = sda_n;
    end
  end

  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge CLK);
      if ((which == 0 && bus.SDA_OE) || (which == 1 && bus.SCL_OE) ||
          (which == 2 && bus.DONE)   || (which == 3 && !bus.SCL_OE) ||
          (which == 4 && s_reading)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic launch(input logic [6:0] a, input logic [7:0] p,
                        input logic [7:0] b0, input logic [7:0] b1, input bit nack);
    slave_nack_addr = nack;
    exp_bytes.push_back({a, 1'b0});
    if (!nack) begin
      exp_bytes.push_back(p);
      exp_bytes.push_back({a, 1'b1});
      rd_bytes.push_back(b0);
      rd_bytes.push_back(b1);
      exp_mack.push_back(1'b0);
      exp_mack.push_back(1'b1);
      model_data = {b0, b1};
    end
    exp_data.push_back(model_data);
    exp_err.push_back(nack);
    @(negedge CLK);
    busy_cnt = 0; done_cnt = 0; start_cnt = 0; stop_cnt = 0;
    bus.ADDRESS = a; bus.POINTER = p; bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    vectors += 6;
    if (bus.SDA_OE !== 1'b0)   begin $display("FAIL rst_sda_oe got %b want 0", bus.SDA_OE); miscompares++; end
    if (bus.SCL_OE !== 1'b0)   begin $display("FAIL rst_scl_oe got %b want 0", bus.SCL_OE); miscompares++; end
    if (bus.BUSY !== 1'b0)     begin $display("FAIL rst_busy got %b want 0", bus.BUSY); miscompares++; end
    if (bus.DONE !== 1'b0)     begin $display("FAIL rst_done got %b want 0", bus.DONE); miscompares++; end
    if (bus.ACK_ERR !== 1'b0)  begin $display("FAIL rst_ack_err got %b want 0", bus.ACK_ERR); miscompares++; end
    if (bus.DATA !== 16'h0000) begin $display("FAIL rst_data got %h want 0000", bus.DATA); miscompares++; end
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    vectors++;
    if (bus.BUSY !== 1'b0) begin $display("FAIL idle_busy got %b want 0", bus.BUSY); miscompares++; end
  endtask

  task automatic finish_txn(input string name, input int quarters, input int starts);
    bit ok;
    logic [15:0] ed;
    logic ee;
    wait_for(2, ok);
    vectors++;
    if (!ok) begin $display("FAIL %s_done got timeout want pulse", name); miscompares++; end
    ed = exp_data.pop_front();
    ee = exp_err.pop_front();
    vectors += 3;
    if (bus.DATA !== ed)   begin $display("FAIL %s_data got %h want %h", name, bus.DATA, ed); miscompares++; end
    if (bus.ACK_ERR !== ee) begin $display("FAIL %s_ack_err got %b want %b", name, bus.ACK_ERR, ee); miscompares++; end
    if (bus.BUSY !== 1'b0) begin $display("FAIL %s_busy_at_done got %b want 0", name, bus.BUSY); miscompares++; end
    $display("txn %s: data=%h ack_err=%b busy_cycles=%0d", name, bus.DATA, bus.ACK_ERR, busy_cnt);
    repeat (3) @(negedge CLK);
    vectors += 4;
    if (busy_cnt != quarters*CLKDIV) begin $display("FAIL %s_busy_len got %0d want %0d", name, busy_cnt, quarters*CLKDIV); miscompares++; end
    if (done_cnt != 1)      begin $display("FAIL %s_done_pulses got %0d want 1", name, done_cnt); miscompares++; end
    if (stop_cnt != 1)      begin $display("FAIL %s_stops got %0d want 1", name, stop_cnt); miscompares++; end
    if (start_cnt != starts) begin $display("FAIL %s_starts got %0d want %0d", name, start_cnt, starts); miscompares++; end
  endtask

  task automatic test_read;
    bit ok;
    int t0, t1, t2, t3;
    launch(7'h48, 8'h00, 8'h19, 8'h80, 1'b0);
    wait_for(0, ok); t0 = cyc;
    wait_for(1, ok); t1 = cyc;
    wait_for(3, ok); t2 = cyc;
    wait_for(1, ok); t3 = cyc;
    vectors += 3;
    if (t1 - t0 != CLKDIV)   begin $display("FAIL quarter_len got %0d want %0d", t1 - t0, CLKDIV); miscompares++; end
    if (t2 - t1 != 2*CLKDIV) begin $display("FAIL scl_low_len got %0d want %0d", t2 - t1, 2*CLKDIV); miscompares++; end
    if (t3 - t2 != 2*CLKDIV) begin $display("FAIL scl_high_len got %0d want %0d", t3 - t2, 2*CLKDIV); miscompares++; end
    finish_txn("read", Q_FULL, 2);
  endtask

  task automatic test_nack;
    launch(7'h22, 8'h5A, 8'hEE, 8'hEE, 1'b1);
    finish_txn("nack", Q_NACK, 1);
    repeat (4) @(negedge CLK);
    vectors++;
    if (bus.ACK_ERR !== 1'b1) begin $display("FAIL ack_err_hold got %b want 1", bus.ACK_ERR); miscompares++; end
  endtask

  task automatic test_busy_ignore;
    bit ok;
    launch(7'h50, 8'h10, 8'hA5, 8'h3C, 1'b0);
    vectors++;
    if (bus.ACK_ERR !== 1'b0) begin $display("FAIL ack_err_clear got %b want 0", bus.ACK_ERR); miscompares++; end
    for (int k = 0; k < 5; k++) begin
      repeat (100) @(negedge CLK);
      bus.ADDRESS = 7'h11; bus.START = 1'b1;
      @(negedge CLK);
      bus.START = 1'b0;
    end
    wait_for(2, ok);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    vectors += 3;
    if (!ok) begin $display("FAIL ignore_done got timeout want pulse"); miscompares++; end
    if (bus.DATA !== exp_data.pop_front()) begin $display("FAIL ignore_data got %h want a53c", bus.DATA); miscompares++; end
    if (bus.ACK_ERR !== exp_err.pop_front()) begin $display("FAIL ignore_ack_err got %b want 0", bus.ACK_ERR); miscompares++; end
    $display("txn ignore: data=%h ack_err=%b busy_cycles=%0d", bus.DATA, bus.ACK_ERR, busy_cnt);
    repeat (3) @(negedge CLK);
    vectors += 3;
    if (bus.BUSY !== 1'b0) begin $display("FAIL start_at_done got busy=%b want 0", bus.BUSY); miscompares++; end
    if (busy_cnt != Q_FULL*CLKDIV) begin $display("FAIL ignore_busy_len got %0d want %0d", busy_cnt, Q_FULL*CLKDIV); miscompares++; end
    if (done_cnt != 1) begin $display("FAIL ignore_done_pulses got %0d want 1", done_cnt); miscompares++; end
  endtask

  task automatic test_reset_midflight;
    bit ok;
    launch(7'h3A, 8'h22, 8'h77, 8'h66, 1'b0);
    wait_for(4, ok);
    repeat (6) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    vectors += 5;
    if (!ok) begin $display("FAIL midrst_reach_rd got timeout want RD_BYTE"); miscompares++; end
    if (bus.SDA_OE !== 1'b0)   begin $display("FAIL midrst_sda_oe got %b want 0", bus.SDA_OE); miscompares++; end
    if (bus.SCL_OE !== 1'b0)   begin $display("FAIL midrst_scl_oe got %b want 0", bus.SCL_OE); miscompares++; end
    if (bus.BUSY !== 1'b0)     begin $display("FAIL midrst_busy got %b want 0", bus.BUSY); miscompares++; end
    if (bus.DATA !== 16'h0000) begin $display("FAIL midrst_data got %h want 0000", bus.DATA); miscompares++; end
    $display("txn midrst: aborted by reset, data=%h", bus.DATA);
    @(negedge CLK);
    exp_bytes.delete(); rd_bytes.delete(); exp_mack.delete(); exp_data.delete(); exp_err.delete();
    model_data = 16'h0000;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    launch(7'h1F, 8'h7E, 8'hC3, 8'h5A, 1'b0);
    finish_txn("b2b_a", Q_FULL, 2);
    launch(7'h60, 8'h01, 8'h01, 8'hFE, 1'b0);
    finish_txn("b2b_b", Q_FULL, 2);
  endtask

  initial begin
    RST_N = 1'b0;
    bus.START = 1'b0; bus.ADDRESS = '0; bus.POINTER = '0;
    test_reset;
    test_read;
    test_nack;
    test_busy_ignore;
    test_reset_midflight;
    test_back_to_back;
    vectors += 2;
    if (exp_bytes.size() != 0) begin $display("FAIL bus_bytes_left got %0d want 0", exp_bytes.size()); miscompares++; end
    if (exp_mack.size() != 0)  begin $display("FAIL master_acks_left got %0d want 0", exp_mack.size()); miscompares++; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
